// File: rtl/ising_pkg.sv
// ising_pkg: shared widths, spin encoding, LFSR taps and FSM states for the dE/2 feeder
package ising_pkg;
  localparam int L_LOG2 = 5;
  localparam int DE_W = 5;
  localparam int RAND_W = 12;
  localparam logic [11:0] LFSR_TAPS = 12'hE08;
  localparam logic SPIN_UP = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;
endpackage

// File: rtl/ising_lfsr12.sv
// ising_lfsr12: 12-bit Fibonacci LFSR (taps 12,11,10,4), advances only when stepped
module ising_lfsr12
  import ising_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [11:0] seed,
  output logic [11:0] q
);
  logic [11:0] r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= seed;
    else if (step) r_q <= {r_q[10:0], ^(r_q & LFSR_TAPS)};
  assign q = r_q;
endmodule

// File: rtl/ising_delta_e_gen.sv
// ising_delta_e_gen: fetches a site and its 4 periodic neighbours, emits dE/2 with a random word
module ising_delta_e_gen #(
  parameter int          L_LOG2    = ising_pkg::L_LOG2,
  parameter int          RAND_W    = ising_pkg::RAND_W,
  parameter logic [11:0] LFSR_SEED = 12'hACE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [L_LOG2-1:0]     site_x,
  input  logic [L_LOG2-1:0]     site_y,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [2*L_LOG2-1:0]   mem_addr,
  input  logic                  mem_rd_data,
  output logic                  de_valid,
  input  logic                  de_ready,
  output logic [4:0]            de_half,
  output logic [RAND_W-1:0]     rand_out,
  output logic [L_LOG2-1:0]     out_x,
  output logic [L_LOG2-1:0]     out_y
);
  import ising_pkg::*;
  state_t r_state, w_next;
  logic [2:0] r_k, r_n, w_n;
  logic [L_LOG2-1:0] r_x, r_y, w_ax, w_ay;
  logic r_sc;
  logic [DE_W-1:0] r_de, w_sum, w_de;
  logic [11:0] w_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == S_IDLE  ? (start ? S_FETCH : S_IDLE) :
             r_state == S_FETCH ? (r_k == 3'd4 ? S_DRAIN : S_FETCH) :
             r_state == S_DRAIN ? S_OUT :
             (de_ready ? S_IDLE : S_OUT);
  end
  // neighbour order: centre, up, down, left, right; wrap falls out of the L_LOG2-bit width
  assign w_ay = r_k == 3'd1 ? r_y - L_LOG2'(1) : r_k == 3'd2 ? r_y + L_LOG2'(1) : r_y;
  assign w_ax = r_k == 3'd3 ? r_x - L_LOG2'(1) : r_k == 3'd4 ? r_x + L_LOG2'(1) : r_x;
  assign w_n = r_n + {2'b00, mem_rd_data};
  assign w_sum = {1'b0, w_n, 1'b0} - DE_W'(4);
  assign w_de = r_sc == SPIN_UP ? w_sum : -w_sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_k <= '0;
      r_n <= '0;
      r_x <= '0;
      r_y <= '0;
      r_sc <= 1'b0;
      r_de <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_x <= site_x;
        r_y <= site_y;
        r_n <= '0;
        r_k <= '0;
      end
      // read k returns in the cycle where r_k == k+1
      if (r_state == S_FETCH) begin
        r_k <= r_k + 3'd1;
        if (r_k == 3'd1) r_sc <= mem_rd_data;
        if (r_k >= 3'd2) r_n <= w_n;
      end
      if (r_state == S_DRAIN) r_de <= w_de;
    end
  ising_lfsr12 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (de_valid & de_ready),
    .seed (LFSR_SEED),
    .q    (w_q)
  );
  assign busy = r_state != S_IDLE;
  assign mem_rd_en = r_state == S_FETCH;
  assign mem_addr = r_state == S_FETCH ? {w_ay, w_ax} : '0;
  assign de_valid = r_state == S_OUT;
  assign de_half = r_de;
  assign rand_out = w_q;
  assign out_x = r_x;
  assign out_y = r_y;
endmodule

// File: tb/tb_ising_delta_e_gen.sv
// tb_ising_delta_e_gen: directed checks of fetch order, dE/2 values, backpressure, LFSR and reset abort
module tb_ising_delta_e_gen;
  logic clk = 0, rst = 1, start = 0, de_ready = 1, mem_rd_data = 0;
  logic [4:0] site_x = 0, site_y = 0, de_half, out_x, out_y;
  logic busy, mem_rd_en, de_valid;
  logic [9:0] mem_addr;
  logic [11:0] rand_out, got_rand, exp_rand;
  logic [4:0] got_x, got_y;
  logic mem [0:1023];
  int pass_cnt = 0, total = 0;

  ising_delta_e_gen dut (
    .clk(clk), .rst(rst), .start(start), .site_x(site_x), .site_y(site_y),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .de_valid(de_valid), .de_ready(de_ready), .de_half(de_half), .rand_out(rand_out),
    .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  function automatic logic [11:0] lfsr_next(input logic [11:0] s);
    return {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
  endfunction

  task automatic set_site(input int x, input int y, input logic c, input logic u,
                          input logic d, input logic l, input logic r);
    for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
    mem[y * 32 + x] = c;
    mem[((y + 31) % 32) * 32 + x] = u;
    mem[((y + 1) % 32) * 32 + x] = d;
    mem[y * 32 + (x + 31) % 32] = l;
    mem[y * 32 + (x + 1) % 32] = r;
  endtask

  task automatic run_site(input int x, input int y, output logic [4:0] de, output int lat);
    @(posedge clk); #1;
    start = 1; site_x = x[4:0]; site_y = y[4:0];
    @(posedge clk); #1;
    start = 0; lat = 1;
    while (!de_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    de = de_half; got_rand = rand_out; got_x = out_x; got_y = out_y;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, mem_rd_en, de_valid, de_half, mem_addr, out_x, out_y} !== '0)
      $display("FAIL reset_outputs got busy=%b rd=%b v=%b de=%b addr=%0d x=%0d y=%0d want all 0",
               busy, mem_rd_en, de_valid, de_half, mem_addr, out_x, out_y);
    else pass_cnt++;
    total++;
    if (rand_out !== 12'hACE) $display("FAIL reset_rand got %h want ace", rand_out); else pass_cnt++;
    rst = 0;
    exp_rand = 12'hACE;
  endtask

  task automatic test_all_up;
    logic [4:0] de; int lat;
    set_site(5, 5, 1, 1, 1, 1, 1);
    run_site(5, 5, de, lat);
    total++; if (lat !== 7) $display("FAIL t1_latency got %0d want 7", lat); else pass_cnt++;
    total++; if (de !== 5'b00100) $display("FAIL t1_de got %b want 00100", de); else pass_cnt++;
    total++; if (got_rand !== 12'hACE) $display("FAIL t1_rand got %h want ace", got_rand); else pass_cnt++;
    total++;
    if (got_x !== 5'd5 || got_y !== 5'd5) $display("FAIL t1_xy got %0d,%0d want 5,5", got_x, got_y);
    else pass_cnt++;
    total++;
    if (busy !== 0 || de_valid !== 0) $display("FAIL t1_idle got busy=%b v=%b want 0 0", busy, de_valid);
    else pass_cnt++;
    exp_rand = 12'h59D;
  endtask

  task automatic test_patterns;
    logic [4:0] de; int lat;
    set_site(10, 20, 0, 1, 1, 1, 1);
    run_site(10, 20, de, lat);
    total++; if (de !== 5'b11100) $display("FAIL t2_neg4 got %b want 11100", de); else pass_cnt++;
    total++; if (got_rand !== 12'h59D) $display("FAIL t2_rand1 got %h want 59d", got_rand); else pass_cnt++;
    set_site(7, 9, 1, 1, 1, 0, 0);
    run_site(7, 9, de, lat);
    total++; if (de !== 5'b00000) $display("FAIL t2_zero got %b want 00000", de); else pass_cnt++;
    total++; if (got_rand !== 12'hB3A) $display("FAIL t2_rand2 got %h want b3a", got_rand); else pass_cnt++;
    set_site(12, 3, 0, 1, 0, 0, 0);
    run_site(12, 3, de, lat);
    total++; if (de !== 5'b00010) $display("FAIL t2_dn_n1 got %b want 00010", de); else pass_cnt++;
    set_site(20, 15, 1, 1, 1, 1, 0);
    run_site(20, 15, de, lat);
    total++; if (de !== 5'b00010) $display("FAIL t2_up_n3 got %b want 00010", de); else pass_cnt++;
    set_site(30, 30, 0, 0, 0, 0, 0);
    run_site(30, 30, de, lat);
    total++; if (de !== 5'b00100) $display("FAIL t2_dn_n0 got %b want 00100", de); else pass_cnt++;
    set_site(31, 31, 1, 0, 0, 0, 1);
    run_site(31, 31, de, lat);
    total++; if (de !== 5'b11110) $display("FAIL t2_wrap_r got %b want 11110", de); else pass_cnt++;
    for (int i = 0; i < 6; i++) exp_rand = lfsr_next(exp_rand);
  endtask

  task automatic test_wrap_addr;
    logic [9:0] exp_a [5];
    exp_a = '{10'd0, 10'd992, 10'd32, 10'd31, 10'd1};
    set_site(0, 0, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    start = 1; site_x = 0; site_y = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 0;
      total++;
      if (mem_rd_en !== 1 || mem_addr !== exp_a[c-1])
        $display("FAIL t3_addr%0d got rd=%b addr=%0d want rd=1 addr=%0d", c, mem_rd_en, mem_addr, exp_a[c-1]);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total++;
    if (mem_rd_en !== 0 || de_valid !== 0) $display("FAIL t3_drain got rd=%b v=%b want 0 0", mem_rd_en, de_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (de_valid !== 1 || de_half !== 5'b11110)
      $display("FAIL t3_result got v=%b de=%b want v=1 de=11110", de_valid, de_half);
    else pass_cnt++;
    @(posedge clk); #1;
    exp_rand = lfsr_next(exp_rand);
  endtask

  task automatic test_backpressure;
    logic [4:0] de; int lat;
    set_site(3, 4, 0, 1, 1, 1, 0);
    de_ready = 0;
    run_site(3, 4, de, lat);
    total++; if (lat !== 7 || de !== 5'b11110) $display("FAIL t4_first got lat=%0d de=%b want 7 11110", lat, de); else pass_cnt++;
    total++; if (got_rand !== exp_rand) $display("FAIL t4_rand got %h want %h", got_rand, exp_rand); else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      start = c[0]; site_x = 9; site_y = 9;
      @(posedge clk); #1;
      total++;
      if (de_valid !== 1 || de_half !== 5'b11110 || rand_out !== exp_rand || out_x !== 5'd3 ||
          out_y !== 5'd4 || mem_rd_en !== 0 || busy !== 1)
        $display("FAIL t4_hold%0d got v=%b de=%b r=%h x=%0d y=%0d rd=%b busy=%b want 1 11110 %h 3 4 0 1",
                 c, de_valid, de_half, rand_out, out_x, out_y, mem_rd_en, busy, exp_rand);
      else pass_cnt++;
    end
    start = 0;
    de_ready = 1;
    @(posedge clk); #1;
    exp_rand = lfsr_next(exp_rand);
    total++;
    if (de_valid !== 0 || busy !== 0 || rand_out !== exp_rand)
      $display("FAIL t4_release got v=%b busy=%b r=%h want 0 0 %h", de_valid, busy, rand_out, exp_rand);
    else pass_cnt++;
    @(posedge clk); #1;
    total++; if (busy !== 0) $display("FAIL t4_no_queue got busy=%b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int gap = 0, guard = 0;
    set_site(15, 15, 1, 1, 1, 1, 1);
    @(posedge clk); #1;
    start = 1; site_x = 15; site_y = 15;
    while (!de_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    while (!de_valid && gap < 20) begin @(posedge clk); #1; gap++; end
    total++; if (gap + 1 !== 8) $display("FAIL t5_throughput got %0d want 8", gap + 1); else pass_cnt++;
    total++; if (de_half !== 5'b00100) $display("FAIL t5_b2b_de got %b want 00100", de_half); else pass_cnt++;
    start = 0;
    guard = 0;
    while (busy && guard < 20) begin @(posedge clk); #1; guard++; end
  endtask

  task automatic test_lfsr_period;
    logic [4:0] de; int lat, steps; logic saw_zero;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    total++; if (rand_out !== 12'hACE) $display("FAIL t6_seed got %h want ace", rand_out); else pass_cnt++;
    set_site(1, 1, 0, 0, 0, 0, 0);
    steps = 0; saw_zero = 0;
    do begin
      run_site(1, 1, de, lat);
      steps++;
      if (rand_out == 12'h000) saw_zero = 1;
    end while (rand_out != 12'hACE && steps < 5000);
    total++; if (steps !== 4095) $display("FAIL t6_period got %0d want 4095", steps); else pass_cnt++;
    total++; if (saw_zero !== 0) $display("FAIL t6_zero got %b want 0", saw_zero); else pass_cnt++;
    exp_rand = 12'hACE;
  endtask

  task automatic test_reset_abort;
    logic [4:0] de; int lat;
    set_site(6, 6, 1, 1, 1, 1, 1);
    @(posedge clk); #1;
    start = 1; site_x = 6; site_y = 6;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    #1;
    total++;
    if (busy !== 0 || mem_rd_en !== 0 || de_valid !== 0)
      $display("FAIL t7_async got busy=%b rd=%b v=%b want 0 0 0", busy, mem_rd_en, de_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 0;
    run_site(6, 6, de, lat);
    total++;
    if (lat !== 7 || de !== 5'b00100 || got_rand !== 12'hACE)
      $display("FAIL t7_fresh got lat=%0d de=%b r=%h want 7 00100 ace", lat, de, got_rand);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_all_up;
    test_patterns;
    test_wrap_addr;
    test_backpressure;
    test_back_to_back;
    test_lfsr_period;
    test_reset_abort;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
